pwm_fader_multi: RTL and testbench

- Multi-channel PWM LED driver. Successor to the single-LED breathing blinker.
- Each of N_CH channels has its own mode (off / static / breathe / blink) and level. All channels share one PWM counter and one step prescaler.
- Channels are configured at runtime through a valid/ready write port.
- Sits between the board LED pins and whichever controller or sequencer writes channel settings.

---
 rtl/pwm_fader_pkg.sv | 14 +
 rtl/fader_channel.sv | 111 +++++++++++
 rtl/pwm_fader_multi.sv | 79 +++++++
 tb/tb_pwm_fader_multi.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fader_pkg.sv
// Shared mode and direction encodings for the multi-channel PWM fader.
package pwm_fader_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/fader_channel.sv
// One LED channel: mode/level state, fade or blink stepping, wrap-aligned
// duty shadow and the PWM comparator.
module fader_channel
  import pwm_fader_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  mode_t            wr_mode,
  input  logic [PWM_W-1:0] wr_level,
  input  logic             step_tick,
  input  logic             duty_load,
  input  logic [PWM_W-1:0] pcnt,
  output logic             led
);

  localparam logic [PWM_W-1:0] LVL_ZERO = PWM_W'(1'b0);
  localparam logic [PWM_W-1:0] LVL_ONE  = PWM_W'(1'b1);

  mode_t            mode_r, mode_s;
  logic [PWM_W-1:0] ceil_r, ceil_s;
  logic [PWM_W-1:0] level_r, level_s;
  logic             dir_r, dir_s;
  logic [PWM_W-1:0] duty_r;
  logic [PWM_W-1:0] eff_s;
  logic             led_r;

  // Next channel state: a write takes priority over a step tick.
  always_comb begin
    mode_s  = mode_r;
    ceil_s  = ceil_r;
    level_s = level_r;
    dir_s   = dir_r;
    if (wr_en) begin
      mode_s = wr_mode;
      case (wr_mode)
        MODE_OFF:     level_s = LVL_ZERO;
        MODE_STATIC:  ceil_s = wr_level;
        MODE_BREATHE: begin
          ceil_s  = wr_level;
          level_s = LVL_ZERO;
          dir_s   = DIR_UP;
        end
        MODE_BLINK: begin
          ceil_s  = wr_level;
          level_s = wr_level;
        end
        default: level_s = level_r;
      endcase
    end else if (step_tick) begin
      case (mode_r)
        MODE_BREATHE: begin
          if (dir_r == DIR_UP) begin
            if (level_r >= ceil_r) begin
              dir_s   = DIR_DOWN;
              level_s = (ceil_r == LVL_ZERO) ? LVL_ZERO : ceil_r - LVL_ONE;
            end else begin
              level_s = level_r + LVL_ONE;
            end
          end else begin
            if (level_r == LVL_ZERO) begin
              dir_s   = DIR_UP;
              level_s = (ceil_r == LVL_ZERO) ? LVL_ZERO : LVL_ONE;
            end else begin
              level_s = level_r - LVL_ONE;
            end
          end
        end
        MODE_BLINK: level_s = (level_r == LVL_ZERO) ? ceil_r : LVL_ZERO;
        default:    level_s = level_r;
      endcase
    end else begin
      level_s = level_r;
    end
  end

  // Level that the duty shadow picks up at the next PWM wrap.
  always_comb begin
    case (mode_r)
      MODE_OFF:    eff_s = LVL_ZERO;
      MODE_STATIC: eff_s = ceil_r;
      default:     eff_s = level_r;
    endcase
  end

  // Channel registers; duty only changes on the wrap clock so periods stay whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= MODE_OFF;
      ceil_r  <= LVL_ZERO;
      level_r <= LVL_ZERO;
      dir_r   <= DIR_UP;
      duty_r  <= LVL_ZERO;
      led_r   <= 1'b0;
    end else begin
      mode_r  <= mode_s;
      ceil_r  <= ceil_s;
      level_r <= level_s;
      dir_r   <= dir_s;
      if (duty_load) begin
        duty_r <= eff_s;
      end
      led_r   <= (pcnt < duty_r);
    end
  end

  assign led = led_r;

endmodule

// File: rtl/pwm_fader_multi.sv
// Multi-channel PWM LED driver: shared PWM counter and step prescaler,
// config write decode, and one fader_channel per LED.
module pwm_fader_multi
  import pwm_fader_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 15000,
  parameter int CH_W     = 2
) (
  input  logic             osc25m,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PWM_W-1:0] cfg_level,
  output logic             cfg_err,
  output logic [N_CH-1:0]  led,
  output logic             pwm_wrap
);

  localparam int               SCNT_W   = $clog2(STEP_DIV);
  localparam logic [PWM_W-1:0] PCNT_MAX = {PWM_W{1'b1}};
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STEP_DIV - 1);

  logic [PWM_W-1:0]  pcnt_r;
  logic [SCNT_W-1:0] scnt_r;
  logic              pwm_wrap_r;
  logic              cfg_ready_r;
  logic              cfg_err_r;
  logic              accept_s;
  logic              in_range_s;
  logic              step_tick_s;
  logic              duty_load_s;

  assign accept_s    = cfg_valid & cfg_ready_r;
  assign in_range_s  = (32'(cfg_ch) < 32'(N_CH));
  assign step_tick_s = (scnt_r == SCNT_MAX);
  assign duty_load_s = (pcnt_r == PCNT_MAX);

  // Shared counters, write-port readiness and the out-of-range error pulse.
  always_ff @(posedge osc25m or posedge rst) begin
    if (rst) begin
      pcnt_r      <= PWM_W'(1'b0);
      scnt_r      <= SCNT_W'(1'b0);
      pwm_wrap_r  <= 1'b0;
      cfg_ready_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      pcnt_r      <= pcnt_r + PWM_W'(1'b1);
      scnt_r      <= step_tick_s ? SCNT_W'(1'b0) : scnt_r + SCNT_W'(1'b1);
      pwm_wrap_r  <= duty_load_s;
      cfg_ready_r <= 1'b1;
      cfg_err_r   <= accept_s & ~in_range_s;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fader_channel #(
      .PWM_W(PWM_W)
    ) u_ch (
      .clk       (osc25m),
      .rst       (rst),
      .wr_en     (accept_s & in_range_s & (32'(cfg_ch) == 32'(i))),
      .wr_mode   (mode_t'(cfg_mode)),
      .wr_level  (cfg_level),
      .step_tick (step_tick_s),
      .duty_load (duty_load_s),
      .pcnt      (pcnt_r),
      .led       (led[i])
    );
  end

  assign cfg_ready = cfg_ready_r;
  assign cfg_err   = cfg_err_r;
  assign pwm_wrap  = pwm_wrap_r;

endmodule

// File: tb/tb_pwm_fader_multi.sv
// Scoreboard bench for pwm_fader_multi: a per-channel behavioural model pushes
// the expected duty of every PWM period; a monitor measures and compares.
module tb_pwm_fader_multi;

  localparam int N_CH     = 4;
  localparam int PWM_W    = 8;
  localparam int STEP_DIV = 4;
  localparam int CH_W     = 3;
  localparam int PER      = 1 << PWM_W;

  logic             osc25m;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [PWM_W-1:0] cfg_level;
  logic             cfg_err;
  logic [N_CH-1:0]  led;
  logic             pwm_wrap;

  pwm_fader_multi #(
    .N_CH(N_CH), .PWM_W(PWM_W), .STEP_DIV(STEP_DIV), .CH_W(CH_W)
  ) dut (
    .osc25m(osc25m), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
    .cfg_err(cfg_err), .led(led), .pwm_wrap(pwm_wrap)
  );

  initial osc25m = 1'b0;
  always #5 osc25m = ~osc25m;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit model_en = 1'b0;
  bit mon_en   = 1'b0;
  int n        = 0;
  int m_mode [N_CH];
  int m_ceil [N_CH];
  int m_t    [N_CH];
  bit exp_err  = 1'b0;
  logic [N_CH*8-1:0] exp_q[$];

  // Breathe is a triangle wave 0..c..0 of period 2c in step ticks since the write.
  function automatic int eff(input int ch);
    int c, p;
    c = m_ceil[ch];
    case (m_mode[ch])
      1: return c;
      2: begin
        if (c == 0) return 0;
        p = m_t[ch] % (2 * c);
        return (p <= c) ? p : 2 * c - p;
      end
      3: return (m_t[ch] % 2 == 0) ? c : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_mode[c] = 0; m_ceil[c] = 0; m_t[c] = 0;
    end
    n = 0;
    exp_err = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge osc25m);
      if (model_en) begin
        bit tick, acc;
        int e;
        logic [N_CH*8-1:0] v;
        tick = ((n % STEP_DIV) == STEP_DIV - 1);
        if ((n % PER) == PER - 1) begin
          for (int c = 0; c < N_CH; c++) begin
            e = eff(c);
            v[c*8 +: 8] = e[7:0];
          end
          exp_q.push_back(v);
        end
        acc = cfg_valid && (n >= 1);
        exp_err = acc && (int'(cfg_ch) >= N_CH);
        for (int c = 0; c < N_CH; c++) begin
          if (acc && int'(cfg_ch) == c) begin
            m_mode[c] = int'(cfg_mode);
            if (cfg_mode != 2'b00) m_ceil[c] = int'(cfg_level);
            m_t[c] = 0;
          end else if (tick) begin
            m_t[c]++;
          end
        end
        n++;
      end
    end
  end

  // ---------------- monitor ----------------
  bit win_open = 1'b0;
  int win_cyc  = 0;
  int win_cnt [N_CH];
  int windows  = 0;

  initial begin
    forever begin
      @(negedge osc25m);
      if (mon_en) begin
        if (exp_err || cfg_err !== 1'b0)
          check("cfg_err", 32'(cfg_err), 32'(exp_err));
        if (pwm_wrap === 1'b1) begin
          if (win_open) begin
            logic [N_CH*8-1:0] ev;
            check("wrap_period", win_cyc, PER);
            if (exp_q.size() == 0) begin
              check("duty_queue_nonempty", 32'd0, 32'd1);
            end else begin
              ev = exp_q.pop_front();
              for (int c = 0; c < N_CH; c++)
                check($sformatf("duty_ch%0d", c), win_cnt[c], 32'(ev[c*8 +: 8]));
            end
            windows++;
          end
          win_open = 1'b1;
          win_cyc  = 0;
          for (int c = 0; c < N_CH; c++) win_cnt[c] = 0;
        end
        if (win_open) begin
          win_cyc++;
          for (int c = 0; c < N_CH; c++) win_cnt[c] += (led[c] === 1'b1) ? 1 : 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input int ch, input int mode, input int lvl);
    @(negedge osc25m);
    cfg_valid = 1'b1;
    cfg_ch    = ch[CH_W-1:0];
    cfg_mode  = mode[1:0];
    cfg_level = lvl[PWM_W-1:0];
    @(negedge osc25m);
    cfg_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge osc25m);
  endtask

  initial begin
    int ch, lvl, n_final;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = 2'b00; cfg_level = '0;
    idle(3);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_pwm_wrap", 32'(pwm_wrap), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0; model_en = 1'b1; mon_en = 1'b1;
    #1 check("ready_before_edge", 32'(cfg_ready), 32'd0);
    idle(1);
    check("ready_after_release", 32'(cfg_ready), 32'd1);

    idle(2 * PER);
    do_write(1, 1, 64);
    idle(3 * PER);
    do_write(0, 1, 200);
    idle(PER + 37);
    do_write(0, 1, 10);
    idle(3 * PER);
    do_write(2, 2, 3);
    do_write(3, 3, 255);
    idle(6 * PER);
    do_write(5, 1, 77);
    idle(2 * PER);

    for (int k = 0; k < 30; k++) begin
      ch  = ($urandom_range(0, 5) == 0) ? $urandom_range(N_CH, 7) : $urandom_range(0, N_CH - 1);
      lvl = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : $urandom_range(0, 255);
      do_write(ch, $urandom_range(0, 3), lvl);
      idle($urandom_range(0, 400));
    end

    do_write(0, 1, 255);
    do_write(2, 2, 5);
    idle(3 * PER);
    idle(2);
    n_final  = n;
    mon_en   = 1'b0;
    model_en = 1'b0;
    check("windows_seen", 32'(windows >= n_final / PER - 2), 32'd1);

    #2 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_ready", 32'(cfg_ready), 32'd0);
    check("async_rst_wrap", 32'(pwm_wrap), 32'd0);
    check("async_rst_err", 32'(cfg_err), 32'd0);
    idle(2);
    rst = 1'b0;
    #1 check("ready_low_after_rerelease", 32'(cfg_ready), 32'd0);
    idle(1);
    check("ready_high_after_rerelease", 32'(cfg_ready), 32'd1);
    check("led_zero_after_rerelease", 32'(led), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
